// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32 decode-to-execute pipeline register (optional WB bypass: ID_EX_WB_BYPASS_EN)
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_alu_op,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,

  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,

  input  logic             flush,

  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_alu_op,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,

  output logic [CNT_W-1:0] stall_cnt
);

  logic            advance;
  logic            hazard;
  logic            rs1_dep;
  logic            rs2_dep;
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;

  // EX slot is free when empty or draining this cycle
  assign advance = ~ex_valid | ex_ready;

  // Load in EX whose destination feeds a source the ID instruction actually reads
  assign rs1_dep = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_dep = id_use_rs2 & (id_rs2 == ex_rd);
  assign hazard  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (rs1_dep | rs2_dep);

  // Flush consumes the ID instruction so it can be discarded on the redirect
  assign id_ready = flush | (advance & ~hazard);

`ifdef ID_EX_WB_BYPASS_EN
  // x0 reads zero; otherwise the same-cycle writeback overrides the register file read
  always_comb begin
    op1_sel = id_rs1_data;
    op2_sel = id_rs2_data;
    if (id_rs1 == 5'd0)
      op1_sel = '0;
    else if (wb_reg_write && (wb_rd == id_rs1))
      op1_sel = wb_data;
    if (id_rs2 == 5'd0)
      op2_sel = '0;
    else if (wb_reg_write && (wb_rd == id_rs2))
      op2_sel = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};

  // x0 reads zero; the register file is relied on for write-first reads
  always_comb begin
    op1_sel = (id_rs1 == 5'd0) ? '0 : id_rs1_data;
    op2_sel = (id_rs2 == 5'd0) ? '0 : id_rs2_data;
  end
`endif

  // Stage register: reset > flush > hold > bubble > capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      stall_cnt    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!advance) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      if (stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end else begin
      ex_valid <= id_valid;
      if (id_valid) begin
        ex_pc        <= id_pc;
        ex_op1       <= op1_sel;
        ex_op2       <= op2_sel;
        ex_imm       <= id_imm;
        ex_rd        <= id_rd;
        ex_alu_op    <= id_alu_op;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_mem_write <= id_mem_write;
      end
    end
  end

endmodule
